memory_in_stream: RTL and testbench

//  Source-side partner of the output collector: holds a local bank of DEPTH words

---
 rtl/memory_in_stream.sv | 127 ++++++++++++
 tb/tb_memory_in_stream.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_in_stream.sv
`default_nettype none
// ============================================================================
// Module     : memory_in_stream
// Description: Local bank of DEPTH words, preloaded by the host over a simple
//              write port. On start, words 0..dat_num are streamed out over a
//              valid/ready interface at up to one word per clock. done pulses
//              for one cycle once the last word has been accepted.
// Ports      : clk, rst_n           - clock, async active-low reset
//              dat_num              - index of last word of the burst (sampled on start)
//              ld_vld/ld_addr/ld_dat - preload write port (legal at any time)
//              start / busy         - burst command / burst in progress
//              out_vld/out_rdy/out_dat - streamed word handshake
//              done                 - one-cycle pulse after the final transfer
// Revision   : 1.0 - initial release
// ============================================================================
module memory_in_stream #(
  parameter int WIDTH      = 256,
  parameter int DEPTH      = 8,
  parameter int log2_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [log2_DEPTH-1:0] dat_num,
  input  logic                  ld_vld,
  input  logic [log2_DEPTH-1:0] ld_addr,
  input  logic [WIDTH-1:0]      ld_dat,
  input  logic                  start,
  output logic                  busy,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [WIDTH-1:0]      out_dat,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    LAST   = 2'd2
  } state_t;

  state_t                state, state_nx;
  logic [WIDTH-1:0]      bank [DEPTH];
  logic [log2_DEPTH-1:0] rd_addr, rd_addr_nx;
  logic [log2_DEPTH-1:0] dat_num_r, dat_num_r_nx;
  logic [WIDTH-1:0]      out_dat_nx;
  logic                  out_vld_nx;
  logic                  done_nx;
  logic                  adv;

  // Bank is never reset. Non-blocking write means a read of the same address
  // on the same edge sees the previous contents.
  always_ff @(posedge clk) begin
    if (ld_vld) begin
      bank[ld_addr] <= ld_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_addr   <= '0;
      dat_num_r <= '0;
      out_dat   <= '0;
      out_vld   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      rd_addr   <= rd_addr_nx;
      dat_num_r <= dat_num_r_nx;
      out_dat   <= out_dat_nx;
      out_vld   <= out_vld_nx;
      done      <= done_nx;
    end
  end

  // The output register refills whenever it is empty or being drained.
  assign adv = ~out_vld | out_rdy;

  always_comb begin
    state_nx     = state;
    rd_addr_nx   = rd_addr;
    dat_num_r_nx = dat_num_r;
    out_dat_nx   = out_dat;
    out_vld_nx   = out_vld;
    done_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          out_dat_nx   = bank[0];
          out_vld_nx   = 1'b1;
          rd_addr_nx   = log2_DEPTH'(1);
          dat_num_r_nx = dat_num;
          state_nx     = (dat_num == '0) ? LAST : STREAM;
        end
      end
      STREAM: begin
        if (adv) begin
          out_dat_nx = bank[rd_addr];
          out_vld_nx = 1'b1;
          // Wraps to 0 after the final index of a full-bank burst; the
          // wrapped address is never used for a read.
          rd_addr_nx = rd_addr + log2_DEPTH'(1);
          if (rd_addr == dat_num_r) begin
            state_nx = LAST;
          end
        end
      end
      LAST: begin
        if (out_rdy) begin
          out_vld_nx = 1'b0;
          done_nx    = 1'b1;
          rd_addr_nx = '0;
          state_nx   = IDLE;
        end
      end
      default: begin
        state_nx   = IDLE;
        out_vld_nx = 1'b0;
        rd_addr_nx = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_memory_in_stream.sv
`default_nettype none
// ============================================================================
// Module     : tb_memory_in_stream
// Description: Directed testbench for memory_in_stream. A bench-side model
//              (word queue per burst plus a shadow bank) is compared against
//              the DUT on every falling edge; literal expectations pin the
//              streamed words, latencies and done counts of each scenario.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_memory_in_stream;

  localparam int WIDTH = 256;
  localparam int DEPTH = 8;
  localparam int LOG2D = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [LOG2D-1:0] dat_num = '0;
  logic             ld_vld = 1'b0;
  logic [LOG2D-1:0] ld_addr = '0;
  logic [WIDTH-1:0] ld_dat = '0;
  logic             start = 1'b0;
  logic             busy;
  logic             out_vld;
  logic             out_rdy = 1'b0;
  logic [WIDTH-1:0] out_dat;
  logic             done;

  memory_in_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .log2_DEPTH(LOG2D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .dat_num (dat_num),
    .ld_vld  (ld_vld),
    .ld_addr (ld_addr),
    .ld_dat  (ld_dat),
    .start   (start),
    .busy    (busy),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_dat (out_dat),
    .done    (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] mbank [DEPTH];
  logic [WIDTH-1:0] q [$];     // words of the current burst still to deliver
  logic [WIDTH-1:0] got [$];   // words the DUT actually handed over
  logic             m_busy = 1'b0;
  logic             m_done = 1'b0;
  int               done_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_busy = 1'b0;
      m_done = 1'b0;
      chk("rst_vld",  {255'd0, out_vld}, '0);
      chk("rst_busy", {255'd0, busy},    '0);
      chk("rst_done", {255'd0, done},    '0);
    end else begin
      logic was_busy;
      chk("vld",  {255'd0, out_vld}, {255'd0, q.size() != 0});
      chk("busy", {255'd0, busy},    {255'd0, m_busy});
      chk("done", {255'd0, done},    {255'd0, m_done});
      if (q.size() != 0) chk("dat", out_dat, q[0]);
      if (done) done_cnt++;
      // predict the effect of the coming rising edge
      was_busy = m_busy;
      m_done   = 1'b0;
      if (q.size() != 0 && out_rdy) begin
        got.push_back(out_dat);
        void'(q.pop_front());
        if (q.size() == 0) begin
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end
      if (!was_busy && start) begin
        for (int k = 0; k <= int'(dat_num); k++) q.push_back(mbank[k]);
        m_busy = 1'b1;
      end
      if (ld_vld) mbank[ld_addr] = ld_dat;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic burst(input logic [LOG2D-1:0] n, input logic [15:0] pat, output int cyc);
    got.delete();
    start   = 1'b1;
    dat_num = n;
    out_rdy = pat[0];
    tick();
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      out_rdy = pat[(cyc + 1) % 16];
      tick();
      cyc++;
    end
    if (!done) chk("burst_timeout", '0, 256'd1);
    out_rdy = 1'b1;
  endtask

  task automatic chk_words(input string name, input int n, input int alt_idx, input int alt_val);
    chk({name, "_len"}, WIDTH'(got.size()), WIDTH'(n));
    for (int i = 0; i < n && i < got.size(); i++) begin
      chk({name, "_word"}, got[i], (i == alt_idx) ? WIDTH'(alt_val) : WIDTH'(8'hA0 + i));
    end
  endtask

  int cyc;
  int d0;

  initial begin
    // reset state
    #12;
    chk("reset_busy", {255'd0, busy},    '0);
    chk("reset_vld",  {255'd0, out_vld}, '0);
    chk("reset_done", {255'd0, done},    '0);
    chk("reset_dat",  out_dat,           '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // preload bank[i] = 0xA0 + i
    for (int i = 0; i < DEPTH; i++) begin
      ld_vld  = 1'b1;
      ld_addr = LOG2D'(i);
      ld_dat  = WIDTH'(8'hA0 + i);
      tick();
    end
    ld_vld = 1'b0;
    tick();

    // 1: full bank, out_rdy held high
    d0 = done_cnt;
    burst(3'd7, 16'hFFFF, cyc);
    chk("t1_latency", WIDTH'(cyc), WIDTH'(8));
    tick();
    chk_words("t1", 8, -1, 0);
    chk("t1_done_cnt", WIDTH'(done_cnt - d0), WIDTH'(1));

    // 2: single word
    d0 = done_cnt;
    burst(3'd0, 16'hFFFF, cyc);
    chk("t2_latency", WIDTH'(cyc), WIDTH'(1));
    tick();
    chk_words("t2", 1, -1, 0);
    chk("t2_done_cnt", WIDTH'(done_cnt - d0), WIDTH'(1));

    // 3: backpressure pattern 1,0,0,1,...
    d0 = done_cnt;
    burst(3'd3, 16'h9999, cyc);
    tick(); tick();
    chk_words("t3", 4, -1, 0);
    chk("t3_done_cnt", WIDTH'(done_cnt - d0), WIDTH'(1));
    chk("t3_idle_vld", {255'd0, out_vld}, '0);

    // 4: start held, dat_num changed mid-burst
    d0 = done_cnt;
    got.delete();
    start = 1'b1; dat_num = 3'd3; out_rdy = 1'b1;
    tick();
    dat_num = 3'd1;
    cyc = 0;
    while (!done && cyc < 100) begin tick(); cyc++; end
    if (!done) chk("t4_timeout", '0, 256'd1);
    start = 1'b0;
    tick(); tick();
    chk_words("t4", 4, -1, 0);
    chk("t4_done_cnt", WIDTH'(done_cnt - d0), WIDTH'(1));
    chk("t4_busy_after", {255'd0, busy}, '0);

    // 5: write bank[2] on the edge it is fetched -> old word streamed
    got.delete();
    start = 1'b1; dat_num = 3'd3; out_rdy = 1'b1;
    tick();
    start = 1'b0;
    tick();
    ld_vld = 1'b1; ld_addr = 3'd2; ld_dat = WIDTH'(8'h55);
    tick();
    ld_vld = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin tick(); cyc++; end
    if (!done) chk("t5_timeout", '0, 256'd1);
    tick();
    chk_words("t5_old", 4, -1, 0);
    burst(3'd3, 16'hFFFF, cyc);
    tick();
    chk_words("t5_new", 4, 2, 8'h55);

    // 6: reset mid-burst
    d0 = done_cnt;
    start = 1'b1; dat_num = 3'd7; out_rdy = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("t6_vld",  {255'd0, out_vld}, '0);
    chk("t6_busy", {255'd0, busy},    '0);
    chk("t6_done", {255'd0, done},    '0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("t6_no_done", WIDTH'(done_cnt - d0), '0);
    burst(3'd7, 16'hFFFF, cyc);
    chk("t6_latency", WIDTH'(cyc), WIDTH'(8));
    tick();
    chk_words("t6", 8, 2, 8'h55);

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
